line_buffer_3row: RTL and testbench
===================================

// Module: line_buffer_3row
// PURPOSE
//  Converts one raster pixel stream into three vertically aligned row streams
//  (row r-2, row r-1, row r) for the 3x3 window filters. Sits between the
//  pixel source and the window/matrix stage: dout1/dout2/dout3 drive that
//  stage's din1/din2/din3 and valid_out drives its valid_in. Two on-chip line
//  memories of PIC_WIDTH entries hold the previous two rows.
// PARAMETERS
//  WIDTH       24   pixel width in bits, packed {R[23:16],G[15:8],B[7:0]}
//  PIC_WIDTH   480  pixels per row (>=3)
//  PIC_HEIGHT  272  rows per frame (>=3)
//  localparam CW = $clog2(PIC_WIDTH), RW = $clog2(PIC_HEIGHT)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  frame_start  in   1      qualified by valid_in: this pixel is row 0, col 0
//  valid_in     in   1      din is valid this cycle
//  din          in   WIDTH  input pixel
//  valid_out    out  1      dout1..3 hold one valid aligned column
//  dout1        out  WIDTH  pixel from row r-2, same column
//  dout2        out  WIDTH  pixel from row r-1, same column
//  dout3        out  WIDTH  pixel from row r (registered copy of din)
//  col_out      out  CW     column index of the current outputs
//  eol          out  1      asserted with valid_out on column PIC_WIDTH-1
// BEHAVIOUR
//  - Reset: valid_out=0, eol=0, dout1..3=0, col_out=0, counters=0,
//    state=FILL0. Line memory contents are not reset (don't-care until written).
//  - Counters: col 0..PIC_WIDTH-1, row 0..PIC_HEIGHT-1; advance only on
//    valid_in. col wraps to 0 at PIC_WIDTH-1 and row increments; row wraps to
//    0 after PIC_HEIGHT-1 at the end of the row.
//  - FSM (advances on the last pixel of a row): FILL0 (row 0) -> FILL1
//    (row 1) -> STREAM (rows 2..PIC_HEIGHT-1) -> FILL0 after the last pixel
//    of row PIC_HEIGHT-1.
//  - Per accepted pixel at column c: read-before-write.
//    dout1<=mem0[c]; dout2<=mem1[c]; dout3<=din; mem0[c]<=mem1[c]; mem1[c]<=din.
//  - Latency: exactly 1 cycle from valid_in to valid_out. valid_out=1 only for
//    pixels accepted in STREAM. eol and col_out are registered alongside.
//  - valid_in=0: counters, FSM, memories and dout* hold; valid_out=0; eol=0.
//  - frame_start & valid_in: overrides counters and state. The pixel is taken
//    as row 0, col 0 in FILL0, even mid-row or mid-frame. No output is
//    produced for it, and previous-row data is overwritten as the rows refill.
//  - frame_start without valid_in: ignored.
//  - Reset mid-frame: immediate return to reset values. The next frame must be
//    flagged with frame_start or start on the first pixel after reset.
//  - Output count per frame: (PIC_HEIGHT-2)*PIC_WIDTH valid_out pulses.
// TESTING (PIC_WIDTH=4, PIC_HEIGHT=4, din=row*16+col in every channel)
//  1 Reset then 16 back-to-back pixels with frame_start on the first ->
//    valid_out for 8 pixels only (rows 2,3). Row 2 col 1: dout1=0x01,
//    dout2=0x11, dout3=0x21. eol is set on col_out=3.
//  2 Same frame with valid_in toggling 1/0 -> identical output sequence;
//    valid_out=0 in every gap cycle; outputs stable across gaps.
//  3 Two consecutive frames, the second with values +0x80 -> the second frame
//    gives no output for rows 0-1. First output: dout1=0x80, dout2=0x90,
//    dout3=0xA0.
//  4 frame_start at row 2 col 2 of frame 1 -> output stops immediately. The
//    next 8 pixels give no valid_out. Output resumes on the 9th pixel with
//    col_out=0.
//  5 Assert rst_n=0 during row 3 -> outputs 0 asynchronously. A new frame
//    after release produces the same outputs as scenario 1.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Purpose: turns one raster pixel stream into three vertically aligned rows (r-2, r-1, r).
// Latency: 1 cycle from an accepted valid_in pixel to valid_out with its aligned column.
// Backpressure: none; valid_in gaps hold counters, FSM, line memories and outputs.
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272,
    localparam int CW = $clog2(PIC_WIDTH),
    localparam int RW = $clog2(PIC_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [CW-1:0]    col_out,
    output logic             eol
);

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state, next_state, cur_state;
    logic [CW-1:0]     col_cnt, next_col, cur_col;
    logic [RW-1:0]     row_cnt, next_row, cur_row;
    logic              restart, last_col, last_row;

    // Previous two rows: mem1 holds row r-1, mem0 holds row r-2.
    logic [WIDTH-1:0]  mem0 [PIC_WIDTH];
    logic [WIDTH-1:0]  mem1 [PIC_WIDTH];

    // Resolve the position of the pixel being accepted (frame_start forces row 0, col 0)
    // and work out where the counters and FSM move next.
    always_comb begin
        restart    = frame_start & valid_in;
        cur_col    = restart ? '0 : col_cnt;
        cur_row    = restart ? '0 : row_cnt;
        cur_state  = restart ? FILL0 : state;
        last_col   = (cur_col == CW'(PIC_WIDTH - 1));
        last_row   = (cur_row == RW'(PIC_HEIGHT - 1));
        next_col   = col_cnt;
        next_row   = row_cnt;
        next_state = state;
        if (valid_in) begin
            next_col   = cur_col + CW'(1);
            next_row   = cur_row;
            next_state = cur_state;
            if (last_col) begin
                next_col = '0;
                next_row = last_row ? '0 : cur_row + RW'(1);
                case (cur_state)
                    FILL0:   next_state = FILL1;
                    FILL1:   next_state = STREAM;
                    STREAM:  next_state = last_row ? FILL0 : STREAM;
                    default: next_state = FILL0;
                endcase
            end
        end
    end

    // Position counters and FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            state   <= next_state;
            col_cnt <= next_col;
            row_cnt <= next_row;
        end
    end

    // Output column: read the old row data before the memories shift (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            eol       <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
            col_out   <= '0;
        end else begin
            valid_out <= valid_in && (cur_state == STREAM);
            eol       <= valid_in && (cur_state == STREAM) && last_col;
            if (valid_in) begin
                dout1   <= mem0[cur_col];
                dout2   <= mem1[cur_col];
                dout3   <= din;
                col_out <= cur_col;
            end
        end
    end

    // Line memories shift one row down per accepted pixel; contents are not reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem0[cur_col] <= mem1[cur_col];
            mem1[cur_col] <= din;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 picture: directed frames plus random traffic.
// Expected values come from a picture model indexed by (row, col) of the current frame.
// Outputs are sampled 1 time unit after the rising edge.
module tb_line_buffer_3row;

    localparam int W  = 24;
    localparam int PW = 4;
    localparam int PH = 4;
    localparam int CW = $clog2(PW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  din = '0;
    logic          valid_out;
    logic [W-1:0]  dout1, dout2, dout3;
    logic [CW-1:0] col_out;
    logic          eol;

    int vectors = 0;
    int miscompares = 0;

    // Model: picture of the current frame, position of the next pixel.
    logic [W-1:0] img [PH][PW];
    int           mr = 0, mc = 0;
    logic         known = 1'b0;
    logic [W-1:0] h1 = '0, h2 = '0, h3 = '0;
    int           pulses = 0;

    line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .valid_in(valid_in),
        .din(din), .valid_out(valid_out), .dout1(dout1), .dout2(dout2),
        .dout3(dout3), .col_out(col_out), .eol(eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat(input int base, input int r, input int c);
        logic [7:0] v;
        v = 8'(base + r * 16 + c);
        return {v, v, v};
    endfunction

    // One clock: drive inputs, predict, then check after the edge.
    task automatic step(input logic v, input logic fs, input logic [W-1:0] d);
        logic exp_vld, exp_eol;
        int   ecol;
        valid_in = v; frame_start = fs; din = d;
        exp_vld = 1'b0; exp_eol = 1'b0; ecol = 0;
        if (v) begin
            if (fs) begin mr = 0; mc = 0; end
            img[mr][mc] = d;
            if (mr >= 2) begin
                exp_vld = 1'b1;
                exp_eol = (mc == PW - 1);
                ecol    = mc;
                h1 = img[mr-2][mc]; h2 = img[mr-1][mc]; h3 = d;
                known = 1'b1;
            end else begin
                known = 1'b0;
            end
            mc++;
            if (mc == PW) begin
                mc = 0;
                mr = (mr == PH - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk); #1;
        chk("valid_out", 32'(valid_out), 32'(exp_vld));
        chk("eol", 32'(eol), 32'(exp_eol));
        if (exp_vld) begin
            pulses++;
            chk("dout1", 32'(dout1), 32'(h1));
            chk("dout2", 32'(dout2), 32'(h2));
            chk("dout3", 32'(dout3), 32'(h3));
            chk("col_out", 32'(col_out), 32'(ecol));
        end else if (!v && known) begin
            chk("dout1_hold", 32'(dout1), 32'(h1));
            chk("dout2_hold", 32'(dout2), 32'(h2));
            chk("dout3_hold", 32'(dout3), 32'(h3));
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input int base, input bit gaps, input bit fs_first);
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                step(1'b1, fs_first && r == 0 && c == 0, pat(base, r, c));
                if (gaps) step(1'b0, 1'b1, 24'hDEADBE);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        chk({tag, "_eol"}, 32'(eol), 32'd0);
        chk({tag, "_dout1"}, 32'(dout1), 32'd0);
        chk({tag, "_dout2"}, 32'(dout2), 32'd0);
        chk({tag, "_dout3"}, 32'(dout3), 32'd0);
        chk({tag, "_col_out"}, 32'(col_out), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: one frame back-to-back, explicit spot check of row 2 col 1
        pulses = 0;
        run_frame(0, 1'b0, 1'b1);
        chk("frame1_pulses", 32'(pulses), 32'((PH - 2) * PW));
        chk("row2col1_ref", 32'(img[0][1]), 32'h010101);

        // 2: same frame with gaps (frame_start held high in gaps must be ignored)
        pulses = 0;
        run_frame(0, 1'b1, 1'b1);
        chk("frame2_pulses", 32'(pulses), 32'((PH - 2) * PW));

        // 3: two consecutive frames, second offset by 0x80
        run_frame(0, 1'b0, 1'b1);
        pulses = 0;
        run_frame(8'h80, 1'b0, 1'b1);
        chk("frame3b_pulses", 32'(pulses), 32'((PH - 2) * PW));

        // 4: frame_start at row 2 col 2 restarts the fill
        for (int i = 0; i < 2 * PW + 2; i++) step(1'b1, i == 0, pat(0, i / PW, i % PW));
        pulses = 0;
        for (int i = 0; i < 2 * PW; i++) step(1'b1, i == 0, pat(8'h40, i / PW, i % PW));
        chk("restart_silent", 32'(pulses), 32'd0);
        step(1'b1, 1'b0, pat(8'h40, 2, 0));
        chk("restart_resume", 32'(pulses), 32'd1);
        for (int i = 1; i < 2 * PW; i++) step(1'b1, 1'b0, pat(8'h40, 2 + i / PW, i % PW));

        // 5: reset during row 3, then a frame starting on the first pixel after reset
        for (int i = 0; i < 3 * PW + 2; i++) step(1'b1, i == 0, pat(8'h10, i / PW, i % PW));
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        mr = 0; mc = 0; known = 1'b0;
        valid_in = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulses = 0;
        run_frame(0, 1'b0, 1'b0);
        chk("post_reset_pulses", 32'(pulses), 32'((PH - 2) * PW));

        // Random traffic: random gaps, random pixels, occasional frame_start
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
